// File: rtl/sha256_stream.sv
// Streaming SHA-256 over NUM_OF_WORDS memory words with on-the-fly padding; writes OUT_WORDS
// digest words back. Define SHA256_MIDSTATE_EN to expose the block-0 chaining value as midstate.
module sha256_stream #(
  parameter int unsigned NUM_OF_WORDS = 20,
  parameter int unsigned OUT_WORDS    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_data
`ifdef SHA256_MIDSTATE_EN
  ,
  output logic [255:0] midstate
`endif
);
  localparam int unsigned NumBlocks = (NUM_OF_WORDS + 18) / 16;
  localparam logic [16:0] NumWords  = 17'(NUM_OF_WORDS);
  localparam logic [16:0] LastIdx   = 17'(NumBlocks * 16 - 1);
  localparam logic [31:0] LenBits   = 32'(NUM_OF_WORDS * 32);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [31:0] Iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {StIdle, StRead, StCompute, StUpdate, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [12:0] blk_q, blk_d;
  logic [15:0] msg_base_q, msg_base_d, out_base_q, out_base_d;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [31:0] wv_q [8];
  logic [31:0] wv_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic        mem_we_q, mem_we_d, done_q, done_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef SHA256_MIDSTATE_EN
  logic [255:0] mid_q, mid_d;
`endif

  logic [16:0] blk_base, cap_idx, nxt_idx, nxt_blk_base;
  logic [31:0] pad_word, t1, t2, w_new;
  logic [2:0]  wr_next;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Datapath: padded-word selection, one compression round, next schedule word.
  always_comb begin
    blk_base     = {blk_q, 4'b0000};
    cap_idx      = blk_base + 17'(cnt_q) - 17'd1;
    nxt_idx      = blk_base + 17'(cnt_q) + 17'd1;
    nxt_blk_base = blk_base + 17'd16;
    wr_next      = 3'(cnt_q + 7'd1);
    if (cap_idx < NumWords)       pad_word = mem_read_data;
    else if (cap_idx == NumWords) pad_word = 32'h8000_0000;
    else if (cap_idx == LastIdx)  pad_word = LenBits;
    else                          pad_word = 32'h0;
    t1 = wv_q[7] + (rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25))
       + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6])) + K[cnt_q[5:0]] + w_q[0];
    t2 = (rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22))
       + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
    w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
  end

  // Memory outputs are registered, so each state sets up the address for the following cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    msg_base_d  = msg_base_q;
    out_base_d  = out_base_q;
    h_d         = h_q;
    wv_d        = wv_q;
    w_d         = w_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
`ifdef SHA256_MIDSTATE_EN
    mid_d       = mid_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          msg_base_d = message_addr;
          out_base_d = output_addr;
          h_d        = Iv;
          blk_d      = '0;
          cnt_d      = '0;
          mem_addr_d = message_addr;
          state_d    = StRead;
        end
      end
      StRead: begin
        if (cnt_q != 7'd0) w_d[4'(cnt_q - 7'd1)] = pad_word;
        if (cnt_q < 7'd15 && nxt_idx < NumWords) mem_addr_d = msg_base_q + nxt_idx[15:0];
        if (cnt_q == 7'd16) begin
          wv_d    = h_q;
          cnt_d   = '0;
          state_d = StCompute;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StCompute: begin
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        wv_d[7] = wv_q[6];
        wv_d[6] = wv_q[5];
        wv_d[5] = wv_q[4];
        wv_d[4] = wv_q[3] + t1;
        wv_d[3] = wv_q[2];
        wv_d[2] = wv_q[1];
        wv_d[1] = wv_q[0];
        wv_d[0] = t1 + t2;
        if (cnt_q == 7'd63) begin
          cnt_d   = '0;
          state_d = StUpdate;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StUpdate: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
`ifdef SHA256_MIDSTATE_EN
        if (blk_q == 13'd0) mid_d = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6], h_d[7]};
`endif
        blk_d = blk_q + 13'd1;
        cnt_d = '0;
        if (32'(blk_q) + 32'd1 < NumBlocks) begin
          state_d = StRead;
          if (nxt_blk_base < NumWords) mem_addr_d = msg_base_q + nxt_blk_base[15:0];
        end else begin
          state_d     = StWrite;
          mem_we_d    = 1'b1;
          mem_addr_d  = out_base_q;
          mem_wdata_d = h_d[0];
        end
      end
      StWrite: begin
        if (32'(cnt_q) + 32'd1 < OUT_WORDS) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = out_base_q + 16'(cnt_q) + 16'd1;
          mem_wdata_d = h_q[wr_next];
          cnt_d       = cnt_q + 7'd1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      blk_q       <= '0;
      msg_base_q  <= '0;
      out_base_q  <= '0;
      h_q         <= '{default: '0};
      wv_q        <= '{default: '0};
      w_q         <= '{default: '0};
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
`ifdef SHA256_MIDSTATE_EN
      mid_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      msg_base_q  <= msg_base_d;
      out_base_q  <= out_base_d;
      h_q         <= h_d;
      wv_q        <= wv_d;
      w_q         <= w_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
`ifdef SHA256_MIDSTATE_EN
      mid_q       <= mid_d;
`endif
    end
  end

  assign done           = done_q;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
`ifdef SHA256_MIDSTATE_EN
  assign midstate       = mid_q;
`endif

endmodule

// File: tb/tb_sha256_stream.sv
// Bench for sha256_stream: four instances (N=1,13,14,20) share one read-only memory. Expected
// writes and done cycles are queued at start; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sha256_stream;
  localparam int unsigned NI = 4;
  localparam int unsigned NW [NI] = '{1, 13, 14, 20};
  localparam int unsigned OW [NI] = '{8, 8, 8, 3};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   msg_addr, out_addr;
  logic [NI-1:0] start_v, done_v, we_v, mclk_v;
  logic [15:0]   addr_v  [NI];
  logic [31:0]   rdata_v [NI];
  logic [31:0]   wdata_v [NI];
`ifdef SHA256_MIDSTATE_EN
  logic [255:0]  mid_v   [NI];
  logic [255:0]  d_mid   [$];
`endif
  logic [31:0]   mem [65536];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stray = 0;

  int unsigned q_inst [$];
  logic [15:0] q_addr [$];
  logic [31:0] q_data [$];
  int unsigned d_inst [$];
  int          d_cyc  [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) for (int i = 0; i < NI; i++) rdata_v[i] <= mem[addr_v[i]];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha256_stream #(.NUM_OF_WORDS(NW[g]), .OUT_WORDS(OW[g])) dut (
      .clk            (clk),
      .reset_n        (rst_n),
      .start          (start_v[g]),
      .message_addr   (msg_addr),
      .output_addr    (out_addr),
      .done           (done_v[g]),
      .mem_clk        (mclk_v[g]),
      .mem_we         (we_v[g]),
      .mem_addr       (addr_v[g]),
      .mem_read_data  (rdata_v[g]),
      .mem_write_data (wdata_v[g])
`ifdef SHA256_MIDSTATE_EN
      ,
      .midstate       (mid_v[g])
`endif
    );
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input int g);
    total++;
    bad++;
    stray++;
    $display("FAIL %s inst %0d: got event at cycle %0d want none", nm, g, cyc);
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (we_v[g]) begin
        if (q_inst.size() == 0) unexpected("stray_write", g);
        else begin
          check($sformatf("write_inst[%0d]", g), 256'(g), 256'(q_inst[0]));
          check($sformatf("write_addr[%0d]", g), 256'(addr_v[g]), 256'(q_addr[0]));
          check($sformatf("write_data[%0d]", g), 256'(wdata_v[g]), 256'(q_data[0]));
          void'(q_inst.pop_front());
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
        end
      end
      if (done_v[g]) begin
        if (d_inst.size() == 0) unexpected("stray_done", g);
        else begin
          check($sformatf("done_inst[%0d]", g), 256'(g), 256'(d_inst[0]));
          check($sformatf("done_cycle[%0d]", g), 256'(cyc), 256'(d_cyc[0]));
`ifdef SHA256_MIDSTATE_EN
          if (g == 3) check("midstate", mid_v[g], d_mid[0]);
          void'(d_mid.pop_front());
`endif
          void'(d_inst.pop_front());
          void'(d_cyc.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] pad_at(input logic [15:0] base, input int unsigned n,
                                         input int unsigned k, input int unsigned total_w);
    if (k < n) return mem[base + 16'(k)];
    if (k == n) return 32'h8000_0000;
    if (k == total_w - 1) return 32'(n * 32);
    return 32'h0;
  endfunction

  // Reference SHA-256 over the padded message, stopping after max_blk blocks.
  function automatic logic [255:0] model(input logic [15:0] base, input int unsigned n,
                                         input int unsigned max_blk);
    logic [31:0] h [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, gg, hh, t1, t2, s0, s1;
    int unsigned nbt, nb;
    nbt = (n + 3 + 15) / 16;
    nb  = (max_blk < nbt) ? max_blk : nbt;
    for (int i = 0; i < 8; i++) h[i] = IVT[i];
    for (int unsigned blk = 0; blk < nb; blk++) begin
      for (int t = 0; t < 16; t++) w[t] = pad_at(base, n, 16 * blk + t, 16 * nbt);
      for (int t = 16; t < 64; t++) begin
        s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
        s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; gg = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
        t1 = hh + s1 + ((e & f) ^ (~e & gg)) + KT[t] + w[t];
        s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
        t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
        hh = gg; gg = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += gg; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  task automatic pulse_start(input int unsigned g);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic run(input int unsigned g, input logic [15:0] ma, input logic [15:0] oa,
                     input logic [255:0] exp_dig, input logic [255:0] exp_mid, input bit poke);
    int unsigned lat;
    int waited;
    lat = ((NW[g] + 3 + 15) / 16) * 82 + OW[g] + 1;
    @(negedge clk);
    msg_addr = ma;
    out_addr = oa;
    for (int w = 0; w < int'(OW[g]); w++) begin
      q_inst.push_back(g);
      q_addr.push_back(oa + 16'(w));
      q_data.push_back(exp_dig[255-32*w -: 32]);
    end
    d_inst.push_back(g);
    d_cyc.push_back(cyc + 1 + int'(lat));
`ifdef SHA256_MIDSTATE_EN
    d_mid.push_back(exp_mid);
`else
    if (exp_mid === 256'bx) $display("note: midstate unknown");
`endif
    pulse_start(g);
    if (poke) begin
      // Ignored starts, one in READ and one in COMPUTE, with different addresses presented.
      repeat (4) @(negedge clk);
      msg_addr = ~ma;
      out_addr = ~oa;
      pulse_start(g);
      repeat (40) @(negedge clk);
      pulse_start(g);
    end
    waited = 0;
    while (d_inst.size() != 0 && waited < int'(lat) + 100) begin
      @(negedge clk);
      waited++;
    end
    if (d_inst.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout inst %0d: got no done want done within %0d cycles", g, lat + 100);
      d_inst.delete();
      d_cyc.delete();
`ifdef SHA256_MIDSTATE_EN
      d_mid.delete();
`endif
    end
    check($sformatf("writes_left[%0d]", g), 256'(q_inst.size()), 256'(0));
    q_inst.delete();
    q_addr.delete();
    q_data.delete();
  endtask

  initial begin
    int stray0;
    rst_n    = 1'b0;
    start_v  = '0;
    msg_addr = '0;
    out_addr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) * 32'h9e37_79b9 ^ 32'h5a5a_0f0f;
    mem[16'h0100] = 32'h6162_6364;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_done[%0d]", i), 256'(done_v[i]), 256'(0));
      check($sformatf("rst_we[%0d]", i), 256'(we_v[i]), 256'(0));
      check($sformatf("rst_addr[%0d]", i), 256'(addr_v[i]), 256'(0));
      check($sformatf("rst_wdata[%0d]", i), 256'(wdata_v[i]), 256'(0));
      check($sformatf("mem_clk[%0d]", i), 256'(mclk_v[i]), 256'(clk));
`ifdef SHA256_MIDSTATE_EN
      check($sformatf("rst_mid[%0d]", i), mid_v[i], 256'(0));
`endif
    end
    rst_n = 1'b1;

    // "abcd": hand-known digest, 91-cycle latency.
    run(0, 16'h0100, 16'h0200,
        256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589,
        256'h0, 1'b0);
    // Padding boundary: N=13 fits one block, N=14 spills the length word into block 1.
    run(1, 16'h1000, 16'h3000, model(16'h1000, 13, 99), 256'h0, 1'b0);
    run(2, 16'h1000, 16'h3100, model(16'h1000, 14, 99), 256'h0, 1'b0);
    // N=20, 3 output words, read and write addresses wrap past 0xFFFF.
    run(3, 16'hfff8, 16'hfffe, model(16'hfff8, 20, 99), model(16'hfff8, 20, 1), 1'b0);

    // Reset during COMPUTE of block 1: no writes, no done, then a clean rerun.
    @(negedge clk);
    msg_addr = 16'hfff8;
    out_addr = 16'h5000;
    pulse_start(3);
    repeat (82 + 17 + 20) @(negedge clk);
    stray0 = stray;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_we", 256'(we_v[3]), 256'(0));
    check("abort_addr", 256'(addr_v[3]), 256'(0));
    check("abort_done", 256'(done_v[3]), 256'(0));
    repeat (200) @(negedge clk);
    check("abort_no_events", 256'(stray), 256'(stray0));
    run(3, 16'hfff8, 16'h5000, model(16'hfff8, 20, 99), model(16'hfff8, 20, 1), 1'b0);

    // Starts during READ and COMPUTE are ignored.
    run(1, 16'h2000, 16'h4000, model(16'h2000, 13, 99), 256'h0, 1'b1);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_stream.md
# sha256_stream

Parametrised successor to the fixed-length SHA-256 core on the hashing datapath. It hashes a message of `NUM_OF_WORDS` 32-bit words of any length read from word-addressed memory and writes the first `OUT_WORDS` digest words back to memory. Padding and block count are generated on the fly, one block at a time, so there is no whole-message buffer. It sits between the top-level controller (start/done) and the shared single-port memory.

## Interface
- `NUM_OF_WORDS`, default 20: message length in 32-bit words, legal range 1..65535.
- `OUT_WORDS`, default 8: digest words written, range 1..8; the digest is truncated from H0 upward.
- `clk` input, 1: clock; all state updates on the rising edge.
- `reset_n` input, 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `start` input, 1: request a hash; sampled only in IDLE.
- `message_addr` input, 16: word address of message word 0; latched on accepted start.
- `output_addr` input, 16: word address for digest word 0; latched on accepted start.
- `done` output, 1: one-cycle completion pulse.
- `mem_clk` output, 1: equals `clk`.
- `mem_we` output, 1: memory write enable.
- `mem_addr` output, 16: memory word address.
- `mem_write_data` output, 32: memory write data.
- `mem_read_data` input, 32: memory read data, valid the cycle after its address.

## Operation
- Block count: B = ceil((NUM_OF_WORDS+3)/16), computed at elaboration.
- Padded word k, for k in 0..16B-1:
  - k < N: memory word message_addr+k.
  - k == N: 0x80000000.
  - k == 16B-2: 0.
  - k == 16B-1: N*32, mod 2^32.
  - All other k: 0.
- States:
  - IDLE: on start, latch both addresses, load H0..H7 with the standard IV, set block j=0, go to READ.
  - READ: 17 cycles.
    - In cycle c < 16, drive `mem_addr` = message_addr+16j+c, but only if 16j+c < N; otherwise hold the address with no access.
    - In cycle c ≥ 1, capture padded word 16j+c-1 into W[c-1].
    - After the last cycle, load a..h from H and go to COMPUTE.
  - COMPUTE: 64 cycles, one round per cycle.
    - 16-word sliding schedule window.
    - Round t uses K[t] and W[t], with W[t] = σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16] for t ≥ 16.
  - UPDATE: 1 cycle.
    - Hi += a..h, all mod 2^32.
    - j++. If j < B go to READ, else go to WRITE.
  - WRITE: OUT_WORDS cycles.
    - In cycle w, drive `mem_we`=1, `mem_addr`=output_addr+w, `mem_write_data`=H[w].
  - DONE: 1 cycle. `done`=1, `mem_we`=0, then IDLE.
- `start` in any state other than IDLE is ignored; no queuing.
- `mem_we` is 1 only in WRITE. No memory writes occur in any other state.
- Address arithmetic wraps mod 2^16.

## Timing
- Reset values: `done`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0, state IDLE.
- `reset_n` low at any edge, including mid-hash, forces IDLE on that edge. Partial digests are discarded and no further writes occur.
- `reset_n` has priority over `start` on the same edge.
- Latency from the edge sampling `start` to the edge where `done` rises: B*82 + OUT_WORDS + 1 cycles.
- Per block: READ 17, COMPUTE 64, UPDATE 1.
- Back-to-back operation: `start` high in the cycle after the `done` pulse is accepted.
- `done` stays low while IDLE; it is a pulse, not a level.

## Configuration
- `SHA256_MIDSTATE_EN` defined:
  - Adds output `midstate` [255:0], holding {H0..H7} captured at the UPDATE of block 0.
  - Valid from the cycle after that UPDATE until the next accepted start; this is for nonce-sweep reuse.
  - Reset value 0.
- `SHA256_MIDSTATE_EN` undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- N=1, mem[message_addr]=0x61626364 ("abcd"), OUT_WORDS=8 -> B=1. Output words are 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589. `done` rises 91 cycles after start.
- N=13 vs N=14 (padding boundary) -> B=1 and B=2 respectively. Digests match a software model. For N=14, word 14 of block 0 is 0x80000000 and the length word sits in block 1.
- N=20, OUT_WORDS=3 -> exactly 3 writes to output_addr..+2 matching model H0..H2; `done` at 2*82+3+1=168 cycles.
- Reset asserted during COMPUTE of block 1 -> IDLE next edge. `mem_we` never asserts, `done` stays 0, and a fresh start then yields the correct digest.
- start pulsed during READ/COMPUTE -> ignored. A single `done` pulse occurs and the digest is unchanged.
- `SHA256_MIDSTATE_EN`, N=20 -> `midstate` equals the model's block-0 chaining value from the UPDATE of block 0 onward.
